// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, flag bit positions,
// controller states and the per-opcode flag update mask.
package alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LLB    = 4'b1000;
   localparam logic [3:0] OP_LHB    = 4'b1001;
   localparam logic [3:0] OP_LS     = 4'b1010;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Bits set in the returned mask are overwritten from the ALU flags; the rest hold.
   function automatic logic [2:0] flag_mask(input logic [3:0] op);
      logic [2:0] m;
      m = 3'b000;
      case (op)
         OP_ADD, OP_SUB: begin
            m[FLAG_Z] = 1'b1;
            m[FLAG_V] = 1'b1;
            m[FLAG_N] = 1'b1;
         end
         OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB, OP_LLB, OP_LHB:
            m[FLAG_Z] = 1'b1;
         OP_LS:   m = 3'b000;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port served last loses a tie.
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic gnt0,
   output logic gnt1,
   output logic gnt_id
);

   logic last_grant;

   always_comb begin
      gnt_id = 1'b0;
      if (req0 && req1)
         gnt_id = ~last_grant;
      else if (req1)
         gnt_id = 1'b1;
      gnt0 = req0 && !gnt_id;
      gnt1 = req1 && gnt_id;
   end

   // Starting at 1 lets port 0 win the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (advance)
         last_grant <= gnt_id;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// load/store address unit (port 1); owns the architectural {Z,V,N} flags.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [15:0] resp_data,
   output logic [2:0]  resp_flag,
   output logic [2:0]  flags,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_out,
   input  logic [2:0]  alu_flag
);

   state_t      state;
   logic        armed;
   logic        id_q;
   logic [3:0]  op_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic        gnt0;
   logic        gnt1;
   logic        gnt_id;
   logic        accept;
   logic [2:0]  mask;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0_valid),
      .req1    (req1_valid),
      .advance (accept),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .gnt_id  (gnt_id)
   );

   // armed keeps both readies low until the first clock after reset release.
   assign req0_ready = armed && (state == IDLE) && gnt0;
   assign req1_ready = armed && (state == IDLE) && gnt1;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign alu_op  = op_q;
   assign alu_in1 = a_q;
   assign alu_in2 = b_q;
   assign mask    = flag_mask(op_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         armed       <= 1'b0;
         id_q        <= 1'b0;
         op_q        <= 4'b0000;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         resp_data   <= 16'h0000;
         resp_flag   <= 3'b000;
         flags       <= 3'b000;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  id_q  <= gnt_id;
                  op_q  <= gnt_id ? req1_op : req0_op;
                  a_q   <= gnt_id ? req1_a  : req0_a;
                  b_q   <= gnt_id ? req1_b  : req0_b;
                  state <= EXEC;
               end
            end
            EXEC: begin
               resp_data   <= alu_out;
               resp_flag   <= alu_flag;
               flags       <= (flags & ~mask) | (alu_flag & mask);
               resp0_valid <= !id_q;
               resp1_valid <= id_q;
               state       <= RESP;
            end
            RESP: begin
               // Only the owning port's ready releases the result.
               if (id_q ? resp1_ready : resp0_ready) begin
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the datapath, a
// transaction-level model predicts grants, results and architectural flags.
module tb_alu_arbiter;
   import alu_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } txn_t;

   typedef struct {
      logic        port;
      logic [15:0] data;
      logic [2:0]  rflag;
      logic [2:0]  flags;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
   logic [15:0] resp_data, alu_in1, alu_in2, alu_out;
   logic [2:0]  resp_flag, flags, alu_flag;
   logic [3:0]  alu_op;

   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   txn_t pend0[$];
   txn_t pend1[$];
   exp_t exp_q[$];
   exp_t cur;
   logic grant_log[$];
   logic cur_active, model_busy, model_last, acc0, acc1;
   logic [2:0] model_flags;
   int   mode0, mode1;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .resp_flag(resp_flag), .flags(flags),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flag(alu_flag)
   );

   // Behavioural ALU: returns {Z,V,N,result}.
   function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      logic        v;
      logic [31:0] d;
      r = 16'h0000;
      v = 1'b0;
      d = {a, a} >> b[3:0];
      case (op)
         4'd0:    begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
         4'd1:    begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
         4'd2:    r = a ^ b;
         4'd4:    r = a << b[3:0];
         4'd5:    r = $signed(a) >>> b[3:0];
         4'd6:    r = d[15:0];
         4'd7:    r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
         4'd8:    r = {a[15:8], b[7:0]};
         4'd9:    r = {b[7:0], a[7:0]};
         4'd10:   r = (a & 16'hFFFE) + (b << 1);
         default: r = 16'h0000;
      endcase
      return {r == 16'h0000, v, r[15], r};
   endfunction

   always_comb begin
      {alu_flag, alu_out} = alu_fn(alu_op, alu_in1, alu_in2);
   end

   // Architectural flag rule: arithmetic updates all, logic/shift/byte ops only Z.
   function automatic logic [2:0] next_flags(input logic [2:0] cur_f, input logic [3:0] op, input logic [2:0] raw);
      logic [2:0] f;
      f = cur_f;
      if (op == 4'd0 || op == 4'd1)
         f = raw;
      else if (op == 4'd2 || (op >= 4'd4 && op <= 4'd9))
         f[2] = raw[2];
      return f;
   endfunction

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cycle);
      end
   endtask

   function automatic txn_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      txn_t t;
      t.op = op; t.a = a; t.b = b;
      return t;
   endfunction

   task automatic monitor_loop();
      logic       p;
      logic [3:0] op;
      logic [15:0] a, b;
      logic [18:0] r;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            cur_active  = 1'b0;
            model_busy  = 1'b0;
            model_last  = 1'b1;
            model_flags = 3'b000;
            acc0 = 1'b0;
            acc1 = 1'b0;
         end else begin
            acc0 = 1'b0;
            acc1 = 1'b0;
            if (model_busy) begin
               checkOutput("ready_while_busy", 32'({req1_ready, req0_ready}), 32'd0);
            end else if (req0_valid || req1_valid) begin
               p = (req0_valid && req1_valid) ? !model_last : req1_valid;
               checkOutput("grant", 32'({req1_ready, req0_ready}), p ? 32'd2 : 32'd1);
               op = p ? req1_op : req0_op;
               a  = p ? req1_a  : req0_a;
               b  = p ? req1_b  : req0_b;
               r  = alu_fn(op, a, b);
               model_flags = next_flags(model_flags, op, r[18:16]);
               model_last  = p;
               model_busy  = 1'b1;
               e.port = p; e.data = r[15:0]; e.rflag = r[18:16];
               e.flags = model_flags; e.cyc = cycle + 2;
               exp_q.push_back(e);
               grant_log.push_back(p);
               if (p) acc1 = 1'b1; else acc0 = 1'b1;
            end
            if (resp0_valid || resp1_valid) begin
               if (!cur_active) begin
                  if (exp_q.size() == 0) begin
                     checkOutput("unexpected_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
                  end else begin
                     cur = exp_q.pop_front();
                     cur_active = 1'b1;
                     checkOutput("resp_port", 32'({resp1_valid, resp0_valid}), cur.port ? 32'd2 : 32'd1);
                     checkOutput("resp_data", 32'(resp_data), 32'(cur.data));
                     checkOutput("resp_flag", 32'(resp_flag), 32'(cur.rflag));
                     checkOutput("arch_flags", 32'(flags), 32'(cur.flags));
                     checkOutput("latency", 32'(cycle), 32'(cur.cyc));
                  end
               end else begin
                  checkOutput("resp_stable", 32'({resp1_valid, resp0_valid, resp_flag, flags, resp_data}),
                              32'({cur.port, !cur.port, cur.rflag, cur.flags, cur.data}));
               end
               if (cur_active && (cur.port ? (resp1_valid && resp1_ready) : (resp0_valid && resp0_ready))) begin
                  cur_active = 1'b0;
                  model_busy = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic driver_loop();
      txn_t t;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            pend0.delete();
            pend1.delete();
         end else begin
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (!req0_valid && pend0.size() > 0) begin
               t = pend0.pop_front();
               req0_op = t.op; req0_a = t.a; req0_b = t.b; req0_valid = 1'b1;
            end
            if (!req1_valid && pend1.size() > 0) begin
               t = pend1.pop_front();
               req1_op = t.op; req1_a = t.a; req1_b = t.b; req1_valid = 1'b1;
            end
         end
         resp0_ready = (mode0 == 2) || (mode0 == 0 && $urandom_range(0, 3) != 0);
         resp1_ready = (mode1 == 2) || (mode1 == 0 && $urandom_range(0, 3) != 0);
      end
   endtask

   task automatic applyStimulus(input int port, input txn_t t);
      if (port == 0) pend0.push_back(t);
      else pend1.push_back(t);
   endtask

   task automatic wait_idle(input int maxc, input string nm);
      int n;
      n = 0;
      while ((pend0.size() > 0 || pend1.size() > 0 || req0_valid || req1_valid ||
              model_busy || exp_q.size() > 0) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checkOutput(nm, 32'(n >= maxc), 32'd0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      txn_t t;
      int   n, sel;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = '0; req0_a = '0; req0_b = '0;
      req1_op = '0; req1_a = '0; req1_b = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      mode0 = 0; mode1 = 0;
      cur_active = 1'b0; model_busy = 1'b0; model_last = 1'b1;
      model_flags = 3'b000; acc0 = 1'b0; acc1 = 1'b0;
      fork
         monitor_loop();
         driver_loop();
      join_none

      repeat (2) @(negedge clk);
      checkOutput("reset_outputs", 32'({req1_ready, req0_ready, resp1_valid, resp0_valid, resp_flag, flags}), 32'd0);
      checkOutput("reset_data", 32'(resp_data), 32'd0);
      checkOutput("reset_alu_drive", 32'({alu_op, alu_in1}), 32'd0);
      #2 rst_n = 1'b1;

      $display("[TB] port 0 ADD overflow");
      applyStimulus(0, mk(OP_ADD, 16'h7FFF, 16'h0001));
      wait_idle(50, "add_done");
      checkOutput("add_data", 32'(resp_data), 32'h8000);
      checkOutput("add_flags", 32'(flags), 32'b011);

      $display("[TB] simultaneous requests after reset");
      do_reset();
      grant_log.delete();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, mk(OP_ADD, 16'(i * 100), 16'h0011));
         applyStimulus(1, mk(OP_LS,  16'(i * 8),   16'h0020));
      end
      wait_idle(100, "tie_done");
      checkOutput("tie_count", 32'(grant_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         checkOutput("tie_order", 32'(grant_log[i]), 32'(i % 2));

      $display("[TB] SUB then address calc");
      applyStimulus(0, mk(OP_SUB, 16'h0005, 16'h0005));
      wait_idle(50, "sub_done");
      checkOutput("sub_flags", 32'(flags), 32'b100);
      applyStimulus(1, mk(OP_LS, 16'h0003, 16'h0002));
      wait_idle(50, "ls_done");
      checkOutput("ls_data", 32'(resp_data), 32'h0006);
      checkOutput("ls_flags", 32'(flags), 32'b100);

      $display("[TB] XOR keeps V and N");
      applyStimulus(0, mk(OP_ADD, 16'h7FFF, 16'h0001));
      applyStimulus(0, mk(OP_XOR, 16'h00FF, 16'h00FF));
      wait_idle(50, "xor_done");
      checkOutput("xor_flags", 32'(flags), 32'b111);

      $display("[TB] response back-pressure");
      mode0 = 1;
      applyStimulus(0, mk(OP_ADD, 16'h1234, 16'h1111));
      n = 0;
      while (!cur_active && n < 20) begin @(negedge clk); n++; end
      checkOutput("hold_resp_seen", 32'(cur_active), 32'd1);
      applyStimulus(1, mk(OP_SUB, 16'h0009, 16'h0004));
      repeat (5) begin
         @(negedge clk);
         checkOutput("hold_req1_ready", 32'(req1_ready), 32'd0);
         checkOutput("hold_data", 32'(resp_data), 32'h2345);
      end
      mode0 = 2;
      repeat (2) @(negedge clk);
      checkOutput("after_hold_req1_ready", 32'(req1_ready), 32'd1);
      wait_idle(50, "hold_done");
      mode0 = 0;
      checkOutput("hold_p1_data", 32'(resp_data), 32'h0005);

      $display("[TB] reset during EXEC");
      do_reset();
      applyStimulus(0, mk(OP_ADD, 16'h7FFF, 16'h0001));
      n = 0;
      while (!acc0 && n < 20) begin @(negedge clk); n++; end
      checkOutput("exec_accept_seen", 32'(acc0), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_ctrl", 32'({req1_ready, req0_ready, resp1_valid, resp0_valid, resp_flag, flags}), 32'd0);
      checkOutput("async_rst_data", 32'({alu_op, resp_data}), 32'd0);
      checkOutput("async_rst_in1", 32'(alu_in1), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("post_rst_quiet", 32'({resp1_valid, resp0_valid, flags}), 32'd0);
      applyStimulus(0, mk(OP_ADD, 16'h0002, 16'h0003));
      wait_idle(50, "post_rst_done");
      checkOutput("post_rst_data", 32'(resp_data), 32'h0005);
      checkOutput("post_rst_flags", 32'(flags), 32'b000);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 2);
         t.op = 4'($urandom_range(0, 15));
         t.a  = 16'($urandom);
         t.b  = ($urandom_range(0, 3) == 0) ? t.a : 16'($urandom);
         if (sel != 1) applyStimulus(0, t);
         t.op = 4'($urandom_range(0, 15));
         t.b  = 16'($urandom);
         if (sel != 0) applyStimulus(1, t);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_idle(5000, "random_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 16-bit ALU between two requesters: port 0 is the execute stage, port 1 is the multicycle load/store address unit. Round-robin arbitration, registered operands, registered result. Owns the architectural flag register {Z,V,N} and applies the per-opcode flag update rules. Sits between the requesters and the ALU instance.

## Interface
- No parameters. Data width 16 and opcode width 4 are fixed.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- req0_op / req1_op  in  4  ALU opcode
- req0_a / req1_a, req0_b / req1_b  in  16  operands In1 / In2
- resp0_valid / resp1_valid  out  1  result available for that port
- resp0_ready / resp1_ready  in  1  requester consumes result
- resp_data  out  16  registered ALU result, shared by both ports
- resp_flag  out  3  registered raw ALU flags {Z,V,N} of this op
- flags  out  3  architectural flag register {Z,V,N}
- alu_in1, alu_in2  out  16  to ALU operand inputs
- alu_op  out  4  to ALU opcode input
- alu_out  in  16  ALU result
- alu_flag  in  3  ALU flags {Z,V,N}

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the arbiter picks one valid requester, and ready is high only for the granted port.
  - Both valid: grant the port not granted last.
  - After reset, last_grant = 1, so port 0 wins the first tie.
  - On accept, latch op, a, b and the port id into operand registers, update last_grant, and go to EXEC.
- EXEC: alu_op/alu_in1/alu_in2 are driven from the operand registers.
  - At the clock edge, capture alu_out into resp_data and alu_flag into resp_flag.
  - Update flags per the mask below, then go to RESP.
- RESP: resp<id>_valid = 1 for the owning port only.
  - resp<id>_ready = 1 → IDLE.
  - Otherwise hold and keep all response registers stable.
- Flag mask applied in EXEC (unlisted bits are kept):
  - 0000 ADD, 0001 SUB: update Z, V, N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, 1000 LLB, 1001 LHB: update Z only.
  - 1010 address calc, and all undefined opcodes: no flag update.
- Undefined opcodes complete normally with whatever alu_out returns (0x0000). No error signalling.
- alu_in1, alu_in2 and alu_op are driven from the operand registers in every state, so they are stable and glitch-free.

## Timing
- Reset values:
  - state = IDLE
  - req*_ready = 0 until the first evaluated cycle; combinationally derived thereafter
  - resp*_valid = 0
  - resp_data = 0x0000, resp_flag = 0, flags = 0
  - operand registers = 0, alu_op = 0000, last_grant = 1
- Latency: accept at edge T → result registered at T+1 → resp_valid high T+1..until consumed.
- Minimum issue interval: 3 cycles (accept, exec, resp with ready=1). No accept while in EXEC or RESP.
- Unaccepted requests must hold valid and payload; the arbiter never drops a valid request.
- A requester asserting valid while its own response is pending is legal; it is accepted only after return to IDLE.
- Reset asserted mid-operation: immediate return to reset values. The outstanding op is discarded, and flags are not updated by it.
- resp_ready on a non-owning port is ignored.

## Structure
- Shared package alu_pkg:
  - opcode constants (OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB, OP_LLB, OP_LHB, OP_LS)
  - flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0)
  - FSM state enum
  - function flag_mask(op) returning the 3-bit update mask
- One sub-module: rr_arb2, a 2-input round-robin grant with last_grant state and an advance strobe on accept.
- ALU is instantiated by the parent, not inside this block.

## Test plan
- Port 0 only: ADD a=0x7FFF b=0x0001 → resp0_valid at T+1, resp_data=0x8000; flags={0,1,1} given an ALU model returning Z=0, V=1, N=1.
- Simultaneous valid on both ports after reset, three ops each → grant order 0,1,0,1,0,1, each with its own correct resp_data.
- SUB 5−5 sets flags={1,0,0}, then address op (1010) a=0x0003 b=0x0002 → flags stay {1,0,0} and resp_data=0x0006 with the ALU model.
- XOR 0x00FF^0x00FF after ADD produced V=1,N=1 → Z becomes 1, V and N stay 1.
- resp0_ready held low 5 cycles with req1_valid high → resp_data stable, req1_ready stays 0 until resp0 consumed, then port 1 accepted next cycle.
- rst_n pulsed low during EXEC → all outputs at reset values asynchronously, flags unchanged from 0. After release, a fresh ADD completes correctly.
